// File: rtl/oled_wr_pkg.sv
// Shared types and constants for the OLED character writer: FSM states,
// message IDs, ASCII codes and the per-column character formatter.
package oled_wr_pkg;

  localparam int unsigned LINE_LEN = 16;
  localparam int unsigned BCD_W    = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    MSG_NONE  = 3'd0,
    MSG_CLR   = 3'd1,
    MSG_PRICE = 3'd2,
    MSG_CENTS = 3'd3,
    MSG_COINS = 3'd4,
    MSG_DISP  = 3'd5
  } msg_id_t;

  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_DOT    = 8'h2E;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;

  function automatic logic is_numeric(input msg_id_t id);
    return (id == MSG_PRICE) || (id == MSG_CENTS) || (id == MSG_COINS);
  endfunction

  function automatic logic [1:0] row_of(input msg_id_t id);
    logic [1:0] row;
    case (id)
      MSG_PRICE: row = 2'd0;
      MSG_CENTS: row = 2'd1;
      MSG_COINS: row = 2'd2;
      default:   row = 2'd3;
    endcase
    return row;
  endfunction

  // Character at column x of a message line; clear and unknown IDs are blank.
  function automatic logic [7:0] line_char(input msg_id_t id, input logic [3:0] x,
                                           input logic [BCD_W-1:0] bcd);
    logic [79:0] txt;
    logic [79:0] sh;
    logic [7:0]  ch;
    ch  = ASCII_SPACE;
    txt = '0;
    sh  = '0;
    case (id)
      MSG_PRICE: txt = "PRICE     ";
      MSG_CENTS: txt = "COIN      ";
      MSG_COINS: txt = "TOTAL     ";
      MSG_DISP:  txt = {ASCII_STAR, "DISPENSE", ASCII_STAR};
      default:   txt = '0;
    endcase
    if (is_numeric(id)) begin
      if (x < 4'd10) begin
        sh = txt << {x, 3'b000};
        ch = sh[79:72];
      end else begin
        case (x)
          4'd10:   ch = ASCII_DOLLAR;
          4'd11:   ch = ASCII_ZERO + {4'h0, bcd[11:8]};
          4'd12:   ch = ASCII_DOT;
          4'd13:   ch = ASCII_ZERO + {4'h0, bcd[7:4]};
          4'd14:   ch = ASCII_ZERO + {4'h0, bcd[3:0]};
          default: ch = ASCII_SPACE;
        endcase
      end
    end else if (id == MSG_DISP && x >= 4'd3 && x < 4'd13) begin
      sh = txt << {x - 4'd3, 3'b000};
      ch = sh[79:72];
    end
    return ch;
  endfunction

endpackage

// File: rtl/oled_char_writer_if.sv
// Request/value inputs from the write controller plus the character port
// toward the OLED driver.
interface oled_char_writer_if;

  logic       clr_reg;
  logic       ld_price;
  logic       ld_cents;
  logic       ld_coins;
  logic       ld_disp;
  logic [7:0] price;
  logic [7:0] cents;
  logic [7:0] coins;
  logic       disp_ready;
  logic       disp_wr_en;
  logic [7:0] disp_char;
  logic [3:0] disp_x;
  logic [1:0] disp_y;
  logic       char_done;

  modport master (
    output clr_reg, ld_price, ld_cents, ld_coins, ld_disp,
    output price, cents, coins, disp_ready,
    input  disp_wr_en, disp_char, disp_x, disp_y, char_done
  );

  modport slave (
    input  clr_reg, ld_price, ld_cents, ld_coins, ld_disp,
    input  price, cents, coins, disp_ready,
    output disp_wr_en, disp_char, disp_x, disp_y, char_done
  );

endinterface

// File: rtl/cents_to_bcd.sv
// Iterative double-dabble: 8-bit binary to three BCD digits, one bit per cycle.
// The start cycle already performs the first shift, so done follows 8 steps.
module cents_to_bcd
  import oled_wr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [7:0]       bin_sr;
  logic [2:0]       cnt;
  logic [BCD_W-1:0] adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_sr <= '0;
      bcd    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // adjust of an all-zero BCD is a no-op, so step 1 is a plain shift
        bcd    <= {11'd0, bin[7]};
        bin_sr <= {bin[6:0], 1'b0};
        cnt    <= 3'd1;
        busy   <= 1'b1;
      end else if (busy) begin
        bcd    <= {adj[10:0], bin_sr[7]};
        bin_sr <= {bin_sr[6:0], 1'b0};
        cnt    <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/oled_char_writer.sv
// Formats one display line (or a full clear) per controller request and streams
// it over a valid/ready character port. OLED_WR_MSG_COUNT_EN adds msg_count.
module oled_char_writer #(
  parameter int unsigned LINE_LEN  = 16,
  parameter int unsigned NUM_LINES = 4
) (
  input  logic               clk,
  input  logic               rst,
  oled_char_writer_if.slave  bus
`ifdef OLED_WR_MSG_COUNT_EN
  ,
  output logic [7:0]         msg_count
`endif
);

  import oled_wr_pkg::*;

  localparam int unsigned NUM_CHARS = LINE_LEN * NUM_LINES;
  localparam int unsigned IDX_W     = $clog2(NUM_CHARS);

  state_t           state, state_n;
  msg_id_t          sel_id, id_q, id_n;
  logic [7:0]       sel_val;
  logic [IDX_W-1:0] idx_q, idx_n, pres_idx, last_idx;
  logic [3:0]       pres_x, x_q, x_n;
  logic [1:0]       pres_y, y_q, y_n;
  logic [7:0]       pres_char, char_q, char_n;
  logic             wr_en_q, wr_en_n, done_q, done_n;
  logic             bcd_start, bcd_busy, bcd_done;
  logic [BCD_W-1:0] bcd;

  // Request priority: clear, price, cents, coins, dispense
  assign sel_id = bus.clr_reg  ? MSG_CLR   :
                  bus.ld_price ? MSG_PRICE :
                  bus.ld_cents ? MSG_CENTS :
                  bus.ld_coins ? MSG_COINS :
                  bus.ld_disp  ? MSG_DISP  : MSG_NONE;

  assign sel_val = bus.ld_price ? bus.price :
                   bus.ld_cents ? bus.cents : bus.coins;

  cents_to_bcd u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (sel_val),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // Character to present next: the current one until it is accepted
  assign pres_idx  = wr_en_q ? idx_q + IDX_W'(1) : idx_q;
  assign pres_x    = 4'(pres_idx % IDX_W'(LINE_LEN));
  assign pres_y    = (id_q == MSG_CLR) ? 2'(pres_idx / IDX_W'(LINE_LEN)) : row_of(id_q);
  assign pres_char = line_char(id_q, pres_x, bcd);
  assign last_idx  = (id_q == MSG_CLR) ? IDX_W'(NUM_CHARS - 1) : IDX_W'(LINE_LEN - 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      id_q    <= MSG_NONE;
      idx_q   <= '0;
      wr_en_q <= 1'b0;
      char_q  <= ASCII_SPACE;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      id_q    <= id_n;
      idx_q   <= idx_n;
      wr_en_q <= wr_en_n;
      char_q  <= char_n;
      x_q     <= x_n;
      y_q     <= y_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (sel_id != MSG_NONE) state_n = is_numeric(sel_id) ? ST_CONV : ST_WRITE;
      ST_CONV:  if (bcd_done && !bcd_busy) state_n = ST_WRITE;
      ST_WRITE: if (wr_en_q && bus.disp_ready && idx_q == last_idx) state_n = ST_DONE;
      ST_DONE:  if (sel_id != id_q) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    id_n      = id_q;
    idx_n     = idx_q;
    wr_en_n   = wr_en_q;
    char_n    = char_q;
    x_n       = x_q;
    y_n       = y_q;
    bcd_start = 1'b0;
    done_n    = (state_n == ST_DONE);
    case (state)
      ST_IDLE: begin
        wr_en_n = 1'b0;
        idx_n   = '0;
        if (sel_id != MSG_NONE) begin
          id_n      = sel_id;
          bcd_start = is_numeric(sel_id);
        end
      end
      ST_WRITE: begin
        if (!wr_en_q || bus.disp_ready) begin
          if (wr_en_q && idx_q == last_idx) begin
            wr_en_n = 1'b0;
          end else begin
            wr_en_n = 1'b1;
            idx_n   = pres_idx;
            char_n  = pres_char;
            x_n     = pres_x;
            y_n     = pres_y;
          end
        end
      end
      default: wr_en_n = 1'b0;
    endcase
  end

`ifdef OLED_WR_MSG_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      msg_count <= '0;
    end else if (state != ST_DONE && state_n == ST_DONE) begin
      msg_count <= msg_count + 8'd1;
    end
  end
`endif

  assign bus.disp_wr_en = wr_en_q;
  assign bus.disp_char  = char_q;
  assign bus.disp_x     = x_q;
  assign bus.disp_y     = y_q;
  assign bus.char_done  = done_q;

endmodule

// File: tb/tb_oled_char_writer.sv
// Directed bench for oled_char_writer: expected characters are queued as each
// request is issued and popped as the driver port accepts them.
module tb_oled_char_writer;

  logic clk = 1'b0;
  logic rst;

  oled_char_writer_if bus();

`ifdef OLED_WR_MSG_COUNT_EN
  logic [7:0] msg_count;
`endif

  oled_char_writer #(.LINE_LEN(16), .NUM_LINES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef OLED_WR_MSG_COUNT_EN
    ,
    .msg_count (msg_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          accepted = 0;
  logic [13:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [13:0] prev_word  = '0;
  logic [13:0] mon_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_line(input logic [1:0] y, input string s);
    for (int i = 0; i < 16; i++) exp_q.push_back({y, 4'(i), 8'(s[i])});
  endtask

  task automatic push_value(input logic [1:0] y, input string lbl, input int v);
    string s;
    s = $sformatf("%s$%0d.%0d%0d ", lbl, v / 100, (v / 10) % 10, v % 10);
    push_line(y, s);
  endtask

  // Scoreboard side: every accepted character and every stall is checked
  always @(negedge clk) begin
    mon_word = {bus.disp_y, bus.disp_x, bus.disp_char};
    if (rst && stall_prev) begin
      chk("stall_valid", 32'(bus.disp_wr_en), 32'(1));
      chk("stall_hold", 32'(mon_word), 32'(prev_word));
    end
    if (rst && bus.disp_wr_en && bus.disp_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed=0x%0h expected=none", mon_word);
      end
      if (exp_q.size() != 0) chk("sb_char", 32'(mon_word), 32'(exp_q.pop_front()));
      accepted++;
    end
    stall_prev = rst && bus.disp_wr_en && !bus.disp_ready;
    prev_word  = mon_word;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    bus.clr_reg  = 1'b0;
    bus.ld_price = 1'b0;
    bus.ld_cents = 1'b0;
    bus.ld_coins = 1'b0;
    bus.ld_disp  = 1'b0;
  endtask

  // Cycles from the request-sampling edge to the first visible disp_wr_en
  task automatic wait_wr(output int k);
    k = 0;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.disp_wr_en) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, input bit toggle, output int k);
    k = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (toggle) bus.disp_ready = ~bus.disp_ready;
      @(negedge clk);
      if (bus.char_done) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(bus.disp_wr_en), 32'(0));
    chk({tag, "_done"},  32'(bus.char_done),  32'(0));
    chk({tag, "_char"},  32'(bus.disp_char),  32'(8'h20));
    chk({tag, "_x"},     32'(bus.disp_x),     32'(0));
    chk({tag, "_y"},     32'(bus.disp_y),     32'(0));
  endtask

  initial begin
    int k;
    int acc0;
    rst = 1'b0;
    drop_all();
    bus.price      = 8'd0;
    bus.cents      = 8'd0;
    bus.coins      = 8'd0;
    bus.disp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    tick();
    rst = 1'b1;
    tick();

    // PRICE 125: latency, completion timing, hold without rewrite
    bus.price    = 8'd125;
    bus.ld_price = 1'b1;
    push_value(2'd0, "PRICE     ", 125);
    wait_wr(k);
    chk("price_latency", 32'(k), 32'(9));
    wait_done(100, 1'b0, k);
    chk("price_done_cycles", 32'(k), 32'(16));
    chk("price_done_wr_en", 32'(bus.disp_wr_en), 32'(0));
    repeat (5) tick();
    chk("price_hold", 32'(bus.char_done), 32'(1));
    chk("price_sb_empty", 32'(exp_q.size()), 32'(0));

    // COIN line, then swap to TOTAL while in DONE
    bus.ld_price = 1'b0;
    bus.ld_cents = 1'b1;
    bus.cents    = 8'd7;
    push_value(2'd1, "COIN      ", 7);
    wait_done(100, 1'b0, k);
    chk("cents_done", 32'(bus.char_done), 32'(1));
    tick();
    bus.ld_cents = 1'b0;
    bus.ld_coins = 1'b1;
    bus.coins    = 8'd255;
    push_value(2'd2, "TOTAL     ", 255);
    @(posedge clk);
    @(negedge clk);
    chk("swap_done_drop", 32'(bus.char_done), 32'(0));
    tick();
    tick();
    bus.coins = 8'd3;
    wait_done(100, 1'b0, k);
    chk("total_done", 32'(bus.char_done), 32'(1));
    chk("total_sb_empty", 32'(exp_q.size()), 32'(0));

    // TOTAL outranks DISPENSE
    tick();
    drop_all();
    tick();
    tick();
    bus.coins    = 8'd0;
    bus.ld_coins = 1'b1;
    bus.ld_disp  = 1'b1;
    push_value(2'd2, "TOTAL     ", 0);
    wait_done(100, 1'b0, k);
    chk("prio_done", 32'(bus.char_done), 32'(1));
    chk("prio_sb_empty", 32'(exp_q.size()), 32'(0));

    // DISPENSE text line
    tick();
    drop_all();
    tick();
    tick();
    bus.ld_disp = 1'b1;
    push_line(2'd3, "   *DISPENSE*   ");
    wait_wr(k);
    chk("disp_latency", 32'(k), 32'(1));
    wait_done(100, 1'b0, k);
    chk("disp_done_cycles", 32'(k), 32'(16));
    chk("disp_sb_empty", 32'(exp_q.size()), 32'(0));

    // Clear with disp_ready toggling
    tick();
    drop_all();
    tick();
    tick();
    bus.clr_reg = 1'b1;
    for (int i = 0; i < 64; i++) exp_q.push_back({2'(i / 16), 4'(i % 16), 8'h20});
    acc0 = accepted;
    wait_done(600, 1'b1, k);
    chk("clr_done", 32'(bus.char_done), 32'(1));
    chk("clr_accepts", 32'(accepted - acc0), 32'(64));
    chk("clr_sb_empty", 32'(exp_q.size()), 32'(0));
    tick();
    bus.disp_ready = 1'b1;
    drop_all();
    tick();
    tick();

    // Reset while character 7 of a PRICE line is presented
    bus.price    = 8'd42;
    bus.ld_price = 1'b1;
    push_value(2'd0, "PRICE     ", 42);
    acc0 = accepted;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (accepted - acc0 == 7) break;
    end
    chk("mid_wr_en", 32'(bus.disp_wr_en), 32'(1));
    chk("mid_x", 32'(bus.disp_x), 32'(7));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midrst");
    tick();
    exp_q.delete();
    push_value(2'd0, "PRICE     ", 42);
    rst = 1'b1;
    wait_done(100, 1'b0, k);
    chk("restart_done", 32'(bus.char_done), 32'(1));
    chk("restart_sb_empty", 32'(exp_q.size()), 32'(0));

`ifdef OLED_WR_MSG_COUNT_EN
    chk("msg_count_one", 32'(msg_count), 32'(1));
    for (int m = 0; m < 256; m++) begin
      tick();
      drop_all();
      tick();
      bus.ld_disp = 1'b1;
      push_line(2'd3, "   *DISPENSE*   ");
      wait_done(60, 1'b0, k);
      if (k == 0) chk("cnt_loop_done", 32'(bus.char_done), 32'(1));
    end
    chk("msg_count_wrap", 32'(msg_count), 32'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
